matrix_stream_ctrl: RTL and testbench

//  Stream front/back end for the 2x2 matrix core (mul_add array). Collects 8 operand bytes

---
 rtl/matrix_stream_ctrl.sv | 113 +++++++++++
 tb/tb_matrix_stream_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_ctrl.sv
// Stream front/back end for the 2x2 matrix core: collects 8 operand bytes, holds them for the
// core, then replays the four results. Optional out_last port enabled by MATRIX_STREAM_LAST_EN.
module matrix_stream_ctrl #(
   parameter int DW = 8,
   parameter int RW = 2 * DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_data,
`ifdef MATRIX_STREAM_LAST_EN
   output logic          out_last,
`endif
   output logic          busy,
   output logic          op_o,
   output logic [DW-1:0] a11_o,
   output logic [DW-1:0] a12_o,
   output logic [DW-1:0] a21_o,
   output logic [DW-1:0] a22_o,
   output logic [DW-1:0] b11_o,
   output logic [DW-1:0] b12_o,
   output logic [DW-1:0] b21_o,
   output logic [DW-1:0] b22_o,
   input  logic [RW-1:0] c11_i,
   input  logic [RW-1:0] c12_i,
   input  logic [RW-1:0] c21_i,
   input  logic [RW-1:0] c22_i
);

   typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;

   state_t        state, state_nxt;
   logic [2:0]    cnt;
   logic [1:0]    idx;
   logic [DW-1:0] opr [8];
   logic [RW-1:0] res [4];
   logic          in_xfer, out_xfer;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && cnt == 3'd7) state_nxt = CALC;
         end
         CALC: state_nxt = SEND;
         SEND: begin
            out_valid = 1'b1;
            if (out_ready && idx == 2'd3) state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign out_data = res[idx];
   assign busy     = (cnt != 3'd0) || (state != LOAD);

`ifdef MATRIX_STREAM_LAST_EN
   assign out_last = out_valid && (idx == 2'd3);
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         idx  <= '0;
         op_o <= 1'b0;
         // NOTE: these small register arrays are reset on purpose: the core must see zero operands
         // and out_data must read zero after reset, so they cannot be left as plain RAM.
         for (int i = 0; i < 8; i++) opr[i] <= '0;
         for (int i = 0; i < 4; i++) res[i] <= '0;
      end else begin
         if (in_xfer) begin
            opr[cnt] <= in_data;
            cnt      <= cnt + 3'd1;
            if (cnt == 3'd0) op_o <= in_op;
         end
         // Core outputs are only trusted after the one-cycle settle in CALC.
         if (state == CALC) begin
            res[0] <= c11_i;
            res[1] <= c12_i;
            res[2] <= c21_i;
            res[3] <= c22_i;
         end
         if (out_xfer) idx <= idx + 2'd1;
      end
   end

   assign a11_o = opr[0];
   assign a12_o = opr[1];
   assign a21_o = opr[2];
   assign a22_o = opr[3];
   assign b11_o = opr[4];
   assign b12_o = opr[5];
   assign b21_o = opr[6];
   assign b22_o = opr[7];

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Self-checking bench for matrix_stream_ctrl: behavioural 2x2 core stub, matrix-level reference
// model, directed frames plus randomized frames with random valid/ready handshakes.
module tb_matrix_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_op;
   logic [7:0]  in_data;
   logic        out_valid, out_ready;
   logic [15:0] out_data;
   logic        busy, op_o;
   logic [7:0]  a11_o, a12_o, a21_o, a22_o, b11_o, b12_o, b21_o, b22_o;
   logic [15:0] c11_i, c12_i, c21_i, c22_i;
`ifdef MATRIX_STREAM_LAST_EN
   logic        out_last;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   matrix_stream_ctrl #(.DW(8), .RW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MATRIX_STREAM_LAST_EN
      .out_last(out_last),
`endif
      .busy(busy), .op_o(op_o),
      .a11_o(a11_o), .a12_o(a12_o), .a21_o(a21_o), .a22_o(a22_o),
      .b11_o(b11_o), .b12_o(b12_o), .b21_o(b21_o), .b22_o(b22_o),
      .c11_i(c11_i), .c12_i(c12_i), .c21_i(c21_i), .c22_i(c22_i)
   );

   // Core stub: mul_add array, combinational, wraps modulo 2^16.
   logic [15:0] xa11, xa12, xa21, xa22, xb11, xb12, xb21, xb22;
   assign xa11 = {8'd0, a11_o};  assign xa12 = {8'd0, a12_o};
   assign xa21 = {8'd0, a21_o};  assign xa22 = {8'd0, a22_o};
   assign xb11 = {8'd0, b11_o};  assign xb12 = {8'd0, b12_o};
   assign xb21 = {8'd0, b21_o};  assign xb22 = {8'd0, b22_o};
   assign c11_i = op_o ? xa11 * xb11 + xa12 * xb21 : xa11 * xb11;
   assign c12_i = op_o ? xa11 * xb12 + xa12 * xb22 : xa12 * xb12;
   assign c21_i = op_o ? xa21 * xb11 + xa22 * xb21 : xa21 * xb21;
   assign c22_i = op_o ? xa21 * xb12 + xa22 * xb22 : xa22 * xb22;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: bytes form A and B row-major; element-wise or matrix product, mod 2^16.
   function automatic void model(input logic op, input logic [7:0] b [8], output logic [15:0] c [4]);
      int am [2][2];
      int bm [2][2];
      int sum;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            am[i][j] = int'(b[2*i+j]);
            bm[i][j] = int'(b[4+2*i+j]);
         end
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            if (op) sum = am[i][0] * bm[0][j] + am[i][1] * bm[1][j];
            else    sum = am[i][j] * bm[i][j];
            c[2*i+j] = sum[15:0];
         end
   endfunction

   // vmode: 0 always valid, 1 every other cycle, 2 random. rmode: 0 always ready,
   // 1 three-cycle stall on word 1, 2 random. in_valid stays high with junk once 8 bytes are in.
   task automatic run_frame(input string tag, input logic op, input logic [7:0] b [8],
                            input int vmode, input int rmode);
      logic [15:0] exp_w [4];
      int sent = 0, got = 0, since = 0, cyc = 0, stalls = 0;
      logic tog = 1'b0;
      logic exp_valid;
      model(op, b, exp_w);
      while (got < 4) begin
         @(negedge clk);
         cyc++;
         if (cyc > 200) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            break;
         end
         if (sent == 8) since++;
         exp_valid = (sent == 8) && (since >= 2);
         check({tag, "_in_ready"}, 32'(in_ready), 32'(sent < 8));
         check({tag, "_out_valid"}, 32'(out_valid), 32'(exp_valid));
         check({tag, "_busy"}, 32'(busy), 32'(sent > 0));
         if (exp_valid) begin
            check({tag, "_word", $sformatf("%0d", got)}, 32'(out_data), 32'(exp_w[got]));
`ifdef MATRIX_STREAM_LAST_EN
            check({tag, "_out_last"}, 32'(out_last), 32'(got == 3));
`endif
         end
         case (rmode)
            0: out_ready = 1'b1;
            1: if (got == 1 && stalls < 3) begin out_ready = 1'b0; stalls++; end
               else out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid && out_ready) got++;
         tog = ~tog;
         if (sent < 8) begin
            case (vmode)
               0: in_valid = 1'b1;
               1: in_valid = tog;
               default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = b[sent];
         end else begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
         end
         in_op = (sent == 0) ? op : 1'($urandom);
         if (in_valid && in_ready && sent < 8) begin
            sent++;
            if (sent == 8) since = 0;
         end
      end
   endtask

   logic [7:0] fb [8];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_op_o", 32'(op_o), 32'd0);
      check("rst_a11", 32'(a11_o), 32'd0);
      check("rst_b22", 32'(b22_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 8; i++) fb[i] = 8'(i + 1);
      run_frame("t1_elem", 1'b0, fb, 0, 0);
      run_frame("t2_matmul", 1'b1, fb, 0, 0);
      run_frame("t3_stall", 1'b1, fb, 0, 1);
      for (int i = 0; i < 8; i++) fb[i] = 8'd255;
      run_frame("t4_mm_wrap", 1'b1, fb, 0, 0);
      run_frame("t4_el_max", 1'b0, fb, 0, 0);

      // Abort a frame after 5 bytes with an asynchronous reset.
      @(negedge clk);
      in_op = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 8'($urandom_range(1, 255));
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("t5_busy_mid", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_op_o", 32'(op_o), 32'd0);
      check("t5_rst_a11", 32'(a11_o), 32'd0);
      check("t5_rst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) fb[i] = 8'(i + 1);
      run_frame("t5_after_rst", 1'b0, fb, 0, 0);

      run_frame("t6_toggle", 1'b1, fb, 1, 0);

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
         run_frame($sformatf("rnd%0d", n), 1'($urandom), fb, 2, 2);
      end

      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_out_valid", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
